if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of pipelined_cpu, together with its IF/ID pipeline register.
- Owns the PC and drives the instruction-memory address.
- Exports the current pc/inst pair, the same observables the CPU-level bench monitors.
- Accepts stall requests from the hazard unit and redirects from the EX-stage branch resolver.
- Keeps saturating fetch, stall and flush counters for pipeline statistics.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of each statistics counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
stall  input  1  hazard unit: hold PC and IF/ID this cycle
branch_taken  input  1  EX stage: redirect fetch, flush IF/ID
branch_target  input  `ADDR_LEN  redirect address
imem_addr  output  `ADDR_LEN  instruction memory address (= pc)
imem_rdata  input  `INSTR_LEN  instruction word, combinational read of imem_addr
pc  output  `ADDR_LEN  current fetch PC
inst  output  `INSTR_LEN  instruction at pc (= imem_rdata)
id_pc  output  `ADDR_LEN  IF/ID register: PC of decoded instruction
id_inst  output  `INSTR_LEN  IF/ID register: instruction to decode
id_valid  output  1  IF/ID register holds a real instruction
fetch_cnt  output  CNT_W  instructions latched into IF/ID
stall_cnt  output  CNT_W  cycles held by stall
flush_cnt  output  CNT_W  redirects taken
align_err  output  1  sticky: a branch_target had nonzero bits [1:0]

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - pc = RESET_PC
  - id_pc = 0; id_inst = `NOP_INST (32'h0000_0000); id_valid = 0
  - all counters = 0; align_err = 0
- Combinational outputs: imem_addr = pc; inst = imem_rdata. The fetch-to-IF/ID latency is one cycle.
- Per rising edge, priority is redirect > stall > advance:
  - Redirect (branch_taken = 1, regardless of stall):
    - pc <= {branch_target[31:2], 2'b00}
    - id_inst <= `NOP_INST; id_valid <= 0; id_pc <= 0
    - flush_cnt++
    - if branch_target[1:0] != 0, align_err <= 1
    - The redirect overrides stall because the older EX-stage branch squashes the stalled ID instruction.
  - Stall (stall = 1, branch_taken = 0):
    - pc, id_pc, id_inst and id_valid hold
    - stall_cnt++
    - imem_rdata is ignored
  - Advance (both 0):
    - id_pc <= pc; id_inst <= imem_rdata; id_valid <= 1
    - pc <= pc + `PC_STEP (4)
    - fetch_cnt++
- Boundary conditions:
  - Arithmetic is modulo 2^ADDR_LEN: pc 32'hFFFF_FFFC advances to 32'h0000_0000, with no flag.
  - A redirect to pc+4 still flushes and counts.
  - A redirect on consecutive cycles: each one flushes and counts, and the last target wins.
  - Counters saturate at all-ones and never wrap.
  - align_err clears only on rst.
  - stall held indefinitely: outputs stay frozen, and only stall_cnt moves.
  - The first cycle after reset release fetches from RESET_PC. id_valid rises one edge later.
- No internal state beyond the PC, the IF/ID register, the counters and align_err. Contains no FSM other than the priority mux above.

Decomposition:
- defines.v gains `NOP_INST, `PC_STEP and `RESET_PC_DEFAULT. These sit alongside the existing `ADDR_LEN and `INSTR_LEN.
- Sub-module if_id_reg holds id_pc, id_inst and id_valid, with inputs en (advance), flush (redirect) and d_pc/d_inst. It is reused for later pipeline registers of the same pattern.
- The PC, the next-PC mux, the counters and align_err stay in if_stage.

Test Plan:
- Reset, then 4 free cycles with imem returning addr^32'hA5A5_0000:
  - pc steps 0, 4, 8, C, 10
  - id_inst sequence is A5A5_0000, A5A5_0004, …
  - id_valid rises on the 2nd edge; fetch_cnt = 4
- stall for 3 cycles at pc = 8:
  - pc stays 8 and id_pc stays 4
  - stall_cnt = 3, fetch_cnt unchanged
  - the next free edge gives id_pc = 8, pc = C
- stall and branch_taken together, with branch_target = 32'h40:
  - pc = 40, id_valid = 0, id_inst = 0
  - flush_cnt = 1, stall_cnt unchanged
- branch_target = 32'h43:
  - pc = 40, align_err = 1
  - align_err stays 1 through 10 further cycles
- Redirect to 32'hFFFF_FFFC, then one advance: pc = 0, id_pc = FFFF_FFFC. Also force fetch_cnt to all-ones via a CNT_W = 4 build: it holds at 4'hF.
- Assert rst mid-stall between clock edges: all outputs reach their reset values before the next edge, and fetch resumes at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its
// pipeline registers.
package if_stage_pkg;

    localparam int ADDR_LEN  = 32;
    localparam int INSTR_LEN = 32;

    typedef logic [ADDR_LEN-1:0]  addr_t;
    typedef logic [INSTR_LEN-1:0] instr_t;

    // Encoding of "no operation" used to squash a pipeline slot.
    localparam instr_t NOP_INST         = 32'h0000_0000;
    // Distance between consecutive sequential fetches.
    localparam addr_t  PC_STEP          = 32'd4;
    // Default boot address.
    localparam addr_t  RESET_PC_DEFAULT = 32'h0000_0000;

    // What the fetch stage does on the coming clock edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } fetch_act_e;

    // Redirect beats stall: the older EX-stage branch squashes whatever
    // the hazard unit was holding in ID.
    function automatic fetch_act_e select_action(input logic stall,
                                                 input logic branch_taken);
        if (branch_taken)
            return ACT_REDIRECT;
        else if (stall)
            return ACT_STALL;
        else
            return ACT_ADVANCE;
    endfunction

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic addr_t align_word(input addr_t a);
        return {a[ADDR_LEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: captures a pc/instruction pair when enabled,
// and is squashed to an invalid NOP on flush (flush has priority).
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   flush,
    input  addr_t  d_pc,
    input  instr_t d_inst,
    output addr_t  q_pc,
    output instr_t q_inst,
    output logic   q_valid
);

    // Pipeline slot: squash on flush, capture on enable, otherwise hold.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_pc    <= '0;
            q_inst  <= NOP_INST;
            q_valid <= 1'b0;
        end else if (flush) begin
            q_pc    <= '0;
            q_inst  <= NOP_INST;
            q_valid <= 1'b0;
        end else if (en) begin
            q_pc    <= d_pc;
            q_inst  <= d_inst;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, feeds the
// IF/ID register and keeps saturating fetch/stall/flush statistics.
module if_stage
    import if_stage_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT,
    parameter int    CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  addr_t            branch_target,
    output addr_t            imem_addr,
    input  instr_t           imem_rdata,
    output addr_t            pc,
    output instr_t           inst,
    output addr_t            id_pc,
    output instr_t           id_inst,
    output logic             id_valid,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             align_err
);

    fetch_act_e act;

    assign act       = select_action(stall, branch_taken);
    assign imem_addr = pc;
    assign inst      = imem_rdata;

    // PC register and sticky misaligned-target flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            align_err <= 1'b0;
        end else begin
            unique case (act)
                ACT_REDIRECT: begin
                    pc <= align_word(branch_target);
                    if (branch_target[1:0] != 2'b00)
                        align_err <= 1'b1;
                end
                ACT_ADVANCE: pc <= pc + PC_STEP;
                default:     ;
            endcase
        end
    end

    // Statistics counters; each saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            unique case (act)
                ACT_ADVANCE:
                    if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_W'(1);
                ACT_STALL:
                    if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
                ACT_REDIRECT:
                    if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .en      (act == ACT_ADVANCE),
        .flush   (act == ACT_REDIRECT),
        .d_pc    (pc),
        .d_inst  (imem_rdata),
        .q_pc    (id_pc),
        .q_inst  (id_inst),
        .q_valid (id_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random stall/redirect
// traffic, compared against a pipeline model built from the fetch rules.
// A second instance with 4-bit counters exercises counter saturation.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] key;

    logic [31:0] imem_addr, imem_rdata, pc, inst, id_pc, id_inst;
    logic        id_valid, align_err;
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;

    logic [31:0] s_imem_addr, s_imem_rdata, s_pc, s_inst, s_id_pc, s_id_inst;
    logic        s_id_valid, s_align_err;
    logic [3:0]  s_fetch_cnt, s_stall_cnt, s_flush_cnt;

    // Instruction memory contents: address scrambled by a changeable key.
    assign imem_rdata   = imem_addr ^ key;
    assign s_imem_rdata = s_imem_addr ^ key;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc(pc), .inst(inst), .id_pc(id_pc),
        .id_inst(id_inst), .id_valid(id_valid), .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .align_err(align_err)
    );

    if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(s_imem_addr),
        .imem_rdata(s_imem_rdata), .pc(s_pc), .inst(s_inst), .id_pc(s_id_pc),
        .id_inst(s_id_inst), .id_valid(s_id_valid), .fetch_cnt(s_fetch_cnt),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .align_err(s_align_err)
    );

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_id_pc, m_id_inst;
    logic        m_id_valid, m_align;
    longint      m_fetch, m_stall, m_flush;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input longint cnt, input int w);
        longint maxv;
        maxv = (64'd1 << w) - 1;
        return (cnt > maxv) ? 32'(maxv) : 32'(cnt);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
        m_align = 1'b0; m_fetch = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic compare_all();
        check("pc",        pc,        m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("inst",      inst,      m_pc ^ key);
        check("id_pc",     id_pc,     m_id_pc);
        check("id_inst",   id_inst,   m_id_inst);
        check("id_valid",  32'(id_valid),  32'(m_id_valid));
        check("align_err", 32'(align_err), 32'(m_align));
        check("fetch_cnt", fetch_cnt, sat(m_fetch, 32));
        check("stall_cnt", stall_cnt, sat(m_stall, 32));
        check("flush_cnt", flush_cnt, sat(m_flush, 32));
        check("s_pc",        s_pc,                m_pc);
        check("s_fetch_cnt", 32'(s_fetch_cnt),    sat(m_fetch, 4));
        check("s_stall_cnt", 32'(s_stall_cnt),    sat(m_stall, 4));
        check("s_flush_cnt", 32'(s_flush_cnt),    sat(m_flush, 4));
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt);
        stall = st; branch_taken = br; branch_target = tgt;
        if (br) begin
            m_pc = {tgt[31:2], 2'b00};
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
            m_flush++;
            if (tgt[1:0] != 2'b00) m_align = 1'b1;
        end else if (st) begin
            m_stall++;
        end else begin
            m_id_pc = m_pc; m_id_inst = m_pc ^ key; m_id_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_fetch++;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        key = 32'hA5A5_0000;
        model_reset();
        #12;
        compare_all();
        check("reset_id_inst", id_inst, 32'h0);
        rst = 1'b0;

        // Free running from the reset PC.
        step(1'b0, 1'b0, 32'h0);
        check("first_id_inst", id_inst, 32'hA5A5_0000);
        check("first_id_valid", 32'(id_valid), 32'd1);
        step(1'b0, 1'b0, 32'h0);
        check("pc_at_8", pc, 32'h8);
        check("id_inst_2", id_inst, 32'hA5A5_0004);

        // Hold for three cycles at pc = 8.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        check("stall_pc", pc, 32'h8);
        check("stall_id_pc", id_pc, 32'h4);
        check("stall_cnt_3", stall_cnt, 32'd3);
        check("fetch_cnt_2", fetch_cnt, 32'd2);
        step(1'b0, 1'b0, 32'h0);
        check("resume_id_pc", id_pc, 32'h8);
        check("resume_pc", pc, 32'hC);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("fetch_cnt_5", fetch_cnt, 32'd5);

        // Redirect wins over a simultaneous stall.
        step(1'b1, 1'b1, 32'h40);
        check("redir_pc", pc, 32'h40);
        check("redir_valid", 32'(id_valid), 32'd0);
        check("redir_flush", flush_cnt, 32'd1);
        check("redir_stall", stall_cnt, 32'd3);

        // Misaligned target: PC is word-aligned, flag is sticky.
        step(1'b0, 1'b1, 32'h43);
        check("misalign_pc", pc, 32'h40);
        check("misalign_flag", 32'(align_err), 32'd1);
        for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0, 32'h0);
        check("align_sticky", 32'(align_err), 32'd1);

        // Address wrap at the top of memory.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

        // Redirect to the sequential address, then back-to-back redirects.
        step(1'b0, 1'b1, m_pc + 32'd4);
        step(1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b1, 32'h200);
        check("last_target_wins", pc, 32'h200);

        // Random traffic with a changing memory image.
        for (int i = 0; i < 300; i++) begin
            key = $urandom;
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), $urandom);
        end
        check("sat_fetch_4bit", 32'(s_fetch_cnt), 32'hF);

        // Indefinite stall: only stall_cnt moves.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0);

        // Asynchronous reset between edges while stalled.
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_valid", 32'(id_valid), 32'd0);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        check("post_rst_pc", pc, 32'h4);
        check("post_rst_id_pc", id_pc, 32'h0);
        check("post_rst_id_inst", id_inst, key);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
